// File: rtl/usb_desc_ctrl.sv
// EP0 GET_DESCRIPTOR engine: decodes the request, looks up the descriptor table,
// and streams ROM bytes as max-packet-size IN packets with ACK/retry/ZLP handling.
module usb_desc_ctrl #(
  parameter int EP0_MPS = 64
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [7:0]  req_type,
  input  logic [7:0]  req_index,
  input  logic [15:0] req_length,
  input  logic        hs_mode,
  input  logic        have_strings,
  output logic [3:0]  tbl_sel,
  input  logic [15:0] tbl_addr,
  input  logic [15:0] tbl_len,
  output logic [15:0] descrom_raddr,
  input  logic [7:0]  descrom_rdata,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_last,
  output logic        tx_zlp,
  input  logic        pkt_ack,
  input  logic        pkt_retry,
  input  logic        abort,
  output logic        stall,
  output logic        done
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_LOOKUP   = 3'd1;
  localparam logic [2:0] S_SEND     = 3'd2;
  localparam logic [2:0] S_WAIT_ACK = 3'd3;
  localparam logic [2:0] S_ZLP      = 3'd4;
  localparam logic [2:0] S_STALL    = 3'd5;

  localparam logic [3:0] SEL_DEV     = 4'd0;
  localparam logic [3:0] SEL_QUAL    = 4'd1;
  localparam logic [3:0] SEL_FSCFG   = 4'd2;
  localparam logic [3:0] SEL_HSCFG   = 4'd3;
  localparam logic [3:0] SEL_BOS     = 4'd4;
  localparam logic [3:0] SEL_STRLANG = 4'd5;
  localparam logic [3:0] SEL_HIDRPT  = 4'd9;

  localparam logic [15:0] MPS_M1 = 16'(EP0_MPS - 1);

  logic [2:0]  r_state;
  logic [3:0]  r_tbl_sel;
  logic        r_oscfg;
  logic [15:0] r_req_len;
  logic [15:0] r_base;
  logic [15:0] r_xfer_len;
  logic [15:0] r_sent;
  logic [15:0] r_pkt_start;
  logic        r_done;

  logic        w_dec_ok;
  logic        w_dec_os;
  logic [3:0]  w_dec_sel;
  logic        w_in_send;
  logic        w_last;
  logic        w_zlp_due;
  logic [15:0] w_xfer_min;
  logic [15:0] w_sent_in_pkt;

  // Returns {supported, other-speed-config, table select}.
  function automatic logic [5:0] f_decode(input logic [7:0] typ, input logic [7:0] idx,
                                          input logic hs, input logic strs);
    logic       ok;
    logic       os;
    logic [3:0] sel;
    ok  = 1'b1;
    os  = 1'b0;
    sel = SEL_DEV;
    case (typ)
      8'h01: sel = SEL_DEV;
      8'h06: sel = SEL_QUAL;
      8'h02: begin
        sel = hs ? SEL_HSCFG : SEL_FSCFG;
        ok  = (idx == 8'd0);
      end
      8'h07: begin
        sel = hs ? SEL_FSCFG : SEL_HSCFG;
        os  = 1'b1;
        ok  = (idx == 8'd0);
      end
      8'h0F: sel = SEL_BOS;
      8'h22: sel = SEL_HIDRPT;
      8'h03: begin
        sel = SEL_STRLANG + {2'b00, idx[1:0]};
        ok  = strs && (idx < 8'd4);
      end
      default: ok = 1'b0;
    endcase
    return {ok, os, sel};
  endfunction

  assign {w_dec_ok, w_dec_os, w_dec_sel} = f_decode(req_type, req_index, hs_mode, have_strings);

  assign w_in_send     = (r_state == S_SEND);
  assign w_sent_in_pkt = r_sent - r_pkt_start;
  assign w_last        = (w_sent_in_pkt == MPS_M1) || (r_sent == r_xfer_len - 16'd1);
  assign w_xfer_min    = (tbl_len < r_req_len) ? tbl_len : r_req_len;
  // A short-by-MPS-multiple transfer needs a ZLP so the host sees the end.
  assign w_zlp_due     = (r_xfer_len < r_req_len) && ((r_xfer_len & MPS_M1) == 16'd0);

  assign req_ready     = (r_state == S_IDLE);
  assign tbl_sel       = r_tbl_sel;
  assign tx_valid      = w_in_send;
  assign tx_last       = w_in_send && w_last;
  assign tx_zlp        = (r_state == S_ZLP);
  assign stall         = (r_state == S_STALL);
  assign done          = r_done;
  assign descrom_raddr = w_in_send ? (r_base + r_sent) : 16'd0;

  // Other-speed config reuses the normal config image with bDescriptorType patched.
  always_comb begin
    tx_data = 8'h00;
    if (w_in_send) begin
      if (r_oscfg && (r_sent == 16'd1))
        tx_data = 8'h07;
      else
        tx_data = descrom_rdata;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= S_IDLE;
      r_tbl_sel   <= 4'd0;
      r_oscfg     <= 1'b0;
      r_req_len   <= 16'd0;
      r_base      <= 16'd0;
      r_xfer_len  <= 16'd0;
      r_sent      <= 16'd0;
      r_pkt_start <= 16'd0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (abort) begin
        r_state <= S_IDLE;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (req_valid) begin
              r_tbl_sel <= w_dec_sel;
              r_oscfg   <= w_dec_os;
              r_req_len <= req_length;
              r_state   <= w_dec_ok ? S_LOOKUP : S_STALL;
            end
          end
          S_LOOKUP: begin
            r_base      <= tbl_addr;
            r_xfer_len  <= w_xfer_min;
            r_sent      <= 16'd0;
            r_pkt_start <= 16'd0;
            r_state     <= (w_xfer_min == 16'd0) ? S_ZLP : S_SEND;
          end
          S_SEND: begin
            if (tx_ready) begin
              r_sent <= r_sent + 16'd1;
              if (w_last)
                r_state <= S_WAIT_ACK;
            end
          end
          S_WAIT_ACK: begin
            if (pkt_retry) begin
              r_sent  <= r_pkt_start;
              r_state <= S_SEND;
            end else if (pkt_ack) begin
              if (r_sent < r_xfer_len) begin
                r_pkt_start <= r_sent;
                r_state     <= S_SEND;
              end else if (w_zlp_due) begin
                r_state <= S_ZLP;
              end else begin
                r_done  <= 1'b1;
                r_state <= S_IDLE;
              end
            end
          end
          S_ZLP: begin
            if (pkt_ack && !pkt_retry) begin
              r_done  <= 1'b1;
              r_state <= S_IDLE;
            end
          end
          S_STALL: r_state <= S_IDLE;
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/usb_desc_ctrl.md
USB_DESC_CTRL -- requirements
Module: usb_desc_ctrl

Interface
REQ-001 Parameter EP0_MPS, default 64: endpoint-0 max packet size in bytes; legal values are 8, 16, 32 and 64.
REQ-002 clk  in  1  sole clock; all state changes on its rising edge.
REQ-003 rstn  in  1  asynchronous, active-low reset.
REQ-004 req_valid/req_ready  in/out  1/1  GET_DESCRIPTOR request handshake; accepted on the cycle both are high.
REQ-005 req_type  in  8  wValue high byte (descriptor type).
REQ-006 req_index  in  8  wValue low byte (descriptor index).
REQ-007 req_length  in  16  wLength.
REQ-008 hs_mode  in  1  1 = link is high speed; sampled on request accept.
REQ-009 have_strings  in  1  1 = string descriptors present.
REQ-010 tbl_sel  out  4  table select: 0 dev, 1 qual, 2 fscfg, 3 hscfg, 4 bos, 5 strlang, 6 strvendor, 7 strproduct, 8 strserial, 9 hidrpt.
REQ-011 tbl_addr/tbl_len  in  16/16  combinational ROM offset and length for tbl_sel.
REQ-012 descrom_raddr/descrom_rdata  out/in  16/8  descriptor ROM port; combinational read.
REQ-013 tx_valid/tx_ready/tx_data/tx_last  out/in/out/out  1/1/8/1  IN-data byte stream; tx_last marks the final byte of a packet.
REQ-014 tx_zlp  out  1  zero-length packet requested.
REQ-015 pkt_ack/pkt_retry  in/in  1/1  host ACKed the current packet / resend the current packet.
REQ-016 abort  in  1  new SETUP or bus reset; cancels the transfer.
REQ-017 stall/done  out/out  1/1  one-cycle pulses: request unsupported / transfer complete.

Function
REQ-018 The block SHALL implement the states IDLE, LOOKUP, SEND, WAIT_ACK, ZLP and STALL; req_ready SHALL equal (state==IDLE).
REQ-019 On accept, the block SHALL latch the request fields and decode tbl_sel as follows: 0x01 -> dev; 0x06 -> qual; 0x02 -> hs_mode ? hscfg : fscfg; 0x07 -> hs_mode ? fscfg : hscfg, with the oscfg flag set; 0x0F -> bos; 0x22 -> hidrpt; 0x03 -> index 0..3 selects 5..8 when have_strings=1.
REQ-020 Any other type, a string index >3, a string request with have_strings=0, or a nonzero index for type 0x02 or 0x07 SHALL go to STALL; stall SHALL pulse for 1 cycle and the block SHALL then return to IDLE.
REQ-021 In LOOKUP (1 cycle), the block SHALL latch base=tbl_addr and xfer_len=min(tbl_len, req_length) as a 16-bit unsigned value, and clear sent and pkt_start.
REQ-022 From LOOKUP, the block SHALL go to ZLP if xfer_len==0, and to SEND otherwise; tx_valid SHALL first rise 2 cycles after accept.
REQ-023 In SEND: descrom_raddr=base+sent (mod 2^16), tx_valid=1, and tx_data=descrom_rdata, except that tx_data SHALL be 0x07 when the oscfg flag is set and sent==1.
REQ-024 On each tx_valid&tx_ready the block SHALL increment sent; tx_last SHALL be 1 when (sent-pkt_start)==EP0_MPS-1 or sent==xfer_len-1; after the tx_last byte the block SHALL go to WAIT_ACK.
REQ-025 In WAIT_ACK, pkt_retry SHALL restore sent=pkt_start and go to SEND.
REQ-026 In WAIT_ACK, pkt_ack with sent<xfer_len SHALL set pkt_start=sent and go to SEND.
REQ-027 In WAIT_ACK, pkt_ack with sent==xfer_len SHALL go to ZLP when xfer_len<req_length and xfer_len%EP0_MPS==0, and otherwise pulse done and go to IDLE.
REQ-028 When pkt_ack and pkt_retry are high in the same cycle, pkt_retry SHALL win.
REQ-029 In ZLP, tx_zlp=1 and tx_valid=0; pkt_retry SHALL hold ZLP; pkt_ack SHALL pulse done and go to IDLE.
REQ-030 tx_valid, once high, SHALL hold with stable tx_data until tx_ready, unless abort is high.
REQ-031 abort SHALL force IDLE on the next edge from any state, without done or stall, and SHALL take priority over all other inputs; req_valid seen during an abort cycle SHALL be ignored.

Reset
REQ-032 While rstn=0: state=IDLE, req_ready=1, and tx_valid, tx_last, tx_zlp, stall, done, tx_data, descrom_raddr, tbl_sel and all counters =0.
REQ-033 Reset asserted mid-transfer SHALL abandon the transfer immediately, with no done pulse.

Verification
REQ-034 EP0_MPS=64, table dev addr 0 len 18, type 0x01, wLength 64 -> 18 bytes starting 0x12,0x01, tx_last on byte 18, ack -> done, no ZLP.
REQ-035 EP0_MPS=64, hs_mode=0, type 0x02, fscfg addr 28 len 67, wLength 255 -> packets of 64 and 3 bytes, raddr 28..94.
REQ-036 hs_mode=1, type 0x07, wLength 9 -> fscfg bytes 0x09,0x07,0x43,..., i.e. byte 1 patched to 0x07 and 9 bytes total.
REQ-037 EP0_MPS=8, bos addr 184 len 24, wLength 255 -> 3x8-byte packets then tx_zlp; a retry after packet 2 resends raddr 192..199.
REQ-038 Type 0x05 -> stall pulse with no tx_valid; type 0x03 index 2 with have_strings=0 -> stall pulse.
REQ-039 abort during packet 2 of fscfg -> IDLE next cycle, no done; a new request is accepted normally afterwards.
